// File: rtl/hs_npu_result_collector.sv
// Result collector: re-aligns the lane-staggered systolic output stream into
// complete rows, buffers them per lane, and serves rows over ready/valid.

// One lane column of the row buffer: storage, write pointer and occupancy.
module hs_npu_result_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  input  logic [PW-1:0]         rptr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  avail,
  output logic                  drop
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wptr;
  logic [CW-1:0]         cnt;
  logic                  full, accept;

  // A pop in the same cycle frees a slot, so a full lane still takes the write.
  assign full   = (cnt == CW'(DEPTH));
  assign accept = wr && (!full || pop);
  assign drop   = wr && full && !pop;
  assign avail  = (cnt != '0);
  assign dout   = mem[rptr];

  // Write pointer and occupancy; write+pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (accept) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Element storage; contents are only meaningful under a nonzero count.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= din;
  end
endmodule

module hs_npu_result_collector #(
  parameter int SIZE       = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             start_i,
  input  logic [31:0]                      expected_rows_i,
  input  logic [SIZE-1:0][DATA_WIDTH-1:0]  lane_data_i,
  input  logic [SIZE-1:0]                  lane_valid_i,
  output logic [SIZE-1:0][DATA_WIDTH-1:0]  row_data_o,
  output logic                             row_valid_o,
  input  logic                             row_ready_i,
  output logic                             row_last_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             overflow_o
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]      state;
  logic [31:0]     row_target, rows_out;
  logic [PW-1:0]   rptr;
  logic [SIZE-1:0] lane_avail, lane_drop;
  logic            collect, arm, pop;

  assign collect     = (state == S_COLLECT);
  assign arm         = (state == S_IDLE) && start_i && (expected_rows_i != '0);
  assign row_valid_o = collect && (&lane_avail);
  assign pop         = row_valid_o && row_ready_i;
  assign row_last_o  = row_valid_o && (rows_out == row_target - 32'd1);
  assign busy_o      = collect;
  assign done_o      = (state == S_DONE);

  // Lane writes are only honoured while collecting; arming a job clears the lanes.
  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    hs_npu_result_lane #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clear (flush || arm),
      .wr    (collect && lane_valid_i[i]),
      .din   (lane_data_i[i]),
      .pop   (pop),
      .rptr  (rptr),
      .dout  (row_data_o[i]),
      .avail (lane_avail[i]),
      .drop  (lane_drop[i])
    );
  end

  // Job FSM, shared read pointer, row accounting and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      row_target <= '0;
      rows_out   <= '0;
      rptr       <= '0;
      overflow_o <= 1'b0;
    end else if (flush) begin
      state      <= S_IDLE;
      rows_out   <= '0;
      rptr       <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (collect && (|lane_drop)) overflow_o <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            if (expected_rows_i != '0) begin
              row_target <= expected_rows_i;
              rows_out   <= '0;
              rptr       <= '0;
              state      <= S_COLLECT;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_COLLECT: begin
          if (pop) begin
            rptr     <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            rows_out <= rows_out + 32'd1;
            if (row_last_o) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
